// File: rtl/fib_pkg.sv
// Shared widths, index limit and FSM state type for the Fibonacci index finder.
// Imported by fib_step_unit and fib_index_finder.
package fib_pkg;

    localparam int FIB_W   = 16;
    localparam int IDX_W   = 5;
    localparam int MAX_IDX = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } fib_state_t;

endpackage

// File: rtl/fib_step_unit.sv
// Holds the consecutive Fibonacci pair (prev, cur) and advances it by one term per cycle.
// The o_prev port exists only when FIB_FLOOR_EN is defined.
module fib_step_unit
    import fib_pkg::*;
#(
    parameter int FIB_W = fib_pkg::FIB_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_advance,
    output logic [FIB_W-1:0] o_cur,
`ifdef FIB_FLOOR_EN
    output logic [FIB_W-1:0] o_prev,
`endif
    output logic             o_carry
);

    logic [FIB_W-1:0] r_prev;
    logic [FIB_W-1:0] r_cur;
    logic [FIB_W:0]   w_sum;

    // One extra bit so a next term beyond the register range is detectable.
    assign w_sum = {1'b0, r_prev} + {1'b0, r_cur};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
            r_cur  <= '0;
        end else if (i_load) begin
            r_prev <= '0;
            r_cur  <= FIB_W'(1);
        end else if (i_advance) begin
            r_prev <= r_cur;
            r_cur  <= w_sum[FIB_W-1:0];
        end
    end

    assign o_cur   = r_cur;
    assign o_carry = w_sum[FIB_W];
`ifdef FIB_FLOOR_EN
    assign o_prev  = r_prev;
`endif

endmodule

// File: rtl/fib_index_finder.sv
// Searches the Fibonacci series for a 16-bit value, reporting membership and smallest index.
// Define FIB_FLOOR_EN to add floor_val and report the floor index on a miss.
module fib_index_finder
    import fib_pkg::*;
#(
    parameter int FIB_W = fib_pkg::FIB_W,
    parameter int IDX_W = fib_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             usr_reset_n,
    input  logic             start,
    input  logic [FIB_W-1:0] value_in,
    output logic             busy,
    output logic             done,
    output logic             is_fib,
    output logic [IDX_W-1:0] fib_index
`ifdef FIB_FLOOR_EN
    ,
    output logic [FIB_W-1:0] floor_val
`endif
);

    fib_state_t       r_state;
    logic [FIB_W-1:0] r_target;
    logic [IDX_W-1:0] r_idx;
    logic             r_is_fib;
    logic [IDX_W-1:0] r_fib_index;
`ifdef FIB_FLOOR_EN
    logic [FIB_W-1:0] r_floor;
    logic [FIB_W-1:0] w_prev;
`endif

    logic [FIB_W-1:0] w_cur;
    logic             w_carry;
    logic             w_accept;
    logic             w_searching;
    logic             w_hit;
    logic             w_over;
    logic             w_advance;

    assign w_searching = (r_state == SEARCH);
    assign w_accept    = start && !w_searching;
    assign w_hit       = (w_cur == r_target);
    assign w_over      = (w_cur > r_target);
    assign w_advance   = w_searching && !w_hit && !w_over && !w_carry;

    fib_step_unit #(
        .FIB_W (FIB_W)
    ) u_step (
        .clk       (clk),
        .rst_n     (usr_reset_n),
        .i_load    (w_accept),
        .i_advance (w_advance),
        .o_cur     (w_cur),
`ifdef FIB_FLOOR_EN
        .o_prev    (w_prev),
`endif
        .o_carry   (w_carry)
    );

    always_ff @(posedge clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            r_state     <= IDLE;
            r_target    <= '0;
            r_idx       <= '0;
            r_is_fib    <= 1'b0;
            r_fib_index <= '0;
`ifdef FIB_FLOOR_EN
            r_floor     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_target <= value_in;
                        r_idx    <= IDX_W'(1);
                        // Zero precedes the series head, so it resolves without searching.
                        if (value_in == '0) begin
                            r_is_fib    <= 1'b1;
                            r_fib_index <= '0;
`ifdef FIB_FLOOR_EN
                            r_floor     <= '0;
`endif
                            r_state     <= DONE;
                        end else begin
                            r_state     <= SEARCH;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SEARCH: begin
                    if (w_hit) begin
                        r_is_fib    <= 1'b1;
                        r_fib_index <= r_idx;
`ifdef FIB_FLOOR_EN
                        r_floor     <= r_target;
`endif
                        r_state     <= DONE;
                    end else if (w_over) begin
                        r_is_fib    <= 1'b0;
`ifdef FIB_FLOOR_EN
                        r_fib_index <= r_idx - IDX_W'(1);
                        r_floor     <= w_prev;
`else
                        r_fib_index <= '0;
`endif
                        r_state     <= DONE;
                    end else if (w_carry) begin
                        // Next term no longer fits: cur is the largest representable term.
                        r_is_fib    <= 1'b0;
`ifdef FIB_FLOOR_EN
                        r_fib_index <= r_idx;
                        r_floor     <= w_cur;
`else
                        r_fib_index <= '0;
`endif
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = w_searching;
    assign done      = (r_state == DONE);
    assign is_fib    = r_is_fib;
    assign fib_index = r_fib_index;
`ifdef FIB_FLOOR_EN
    assign floor_val = r_floor;
`endif

endmodule

// File: tb/tb_fib_index_finder.sv
// Randomised and directed bench for fib_index_finder against a series-lookup model.
// Honours FIB_FLOOR_EN for the floor_val port and miss-index expectations.
module tb_fib_index_finder;

    logic        clk;
    logic        usr_reset_n;
    logic        start;
    logic [15:0] value_in;
    logic        busy;
    logic        done;
    logic        is_fib;
    logic [4:0]  fib_index;
`ifdef FIB_FLOOR_EN
    logic [15:0] floor_val;
`endif

    fib_index_finder dut (
        .clk         (clk),
        .usr_reset_n (usr_reset_n),
        .start       (start),
        .value_in    (value_in),
        .busy        (busy),
        .done        (done),
        .is_fib      (is_fib),
        .fib_index   (fib_index)
`ifdef FIB_FLOOR_EN
        ,
        .floor_val   (floor_val)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit is_fib;
        int idx;
        int floor_v;
        int lat;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   busy_cnt = 0;
    int   done_seen = 0;
    int   last_is_fib, last_idx, last_floor, last_lat;

    function automatic int fibn(input int n);
        int a = 0;
        int b = 1;
        int t;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Walk the series in order; one busy cycle per term examined.
    function automatic exp_t model(input int v);
        exp_t e;
        e.is_fib = 0; e.idx = 0; e.floor_v = 0; e.lat = 0;
        if (v == 0) begin
            e.is_fib = 1;
            return e;
        end
        for (int n = 1; n <= 24; n++) begin
            if (fibn(n) == v) begin
                e.is_fib = 1; e.idx = n; e.floor_v = v; e.lat = n;
                return e;
            end
            if (fibn(n) > v) begin
                e.idx = n - 1; e.floor_v = fibn(n - 1); e.lat = n;
`ifndef FIB_FLOOR_EN
                e.idx = 0;
`endif
                return e;
            end
        end
        e.idx = 24; e.floor_v = fibn(24); e.lat = 24;
`ifndef FIB_FLOOR_EN
        e.idx = 0;
`endif
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Compare process: every done pulse is matched against the oldest accepted request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!usr_reset_n) begin
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (done) begin
                    done_seen++;
                    if (q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL spurious_done: got done=1 expected no pending request");
                    end else begin
                        e = q.pop_front();
                        chk("is_fib", int'(is_fib), int'(e.is_fib));
                        chk("fib_index", int'(fib_index), e.idx);
                        chk("latency", busy_cnt, e.lat);
`ifdef FIB_FLOOR_EN
                        chk("floor_val", int'(floor_val), e.floor_v);
                        last_floor = int'(floor_val);
`endif
                        last_is_fib = int'(is_fib);
                        last_idx    = int'(fib_index);
                        last_lat    = busy_cnt;
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    task automatic issue(input int v);
        start    = 1'b1;
        value_in = 16'(v);
        q.push_back(model(v));
        @(posedge clk);
        #1;
        start    = 1'b0;
        value_in = 16'($urandom);
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            chk("done_timeout", 0, 1);
            q.delete();
        end
        #1;
    endtask

    initial begin
        exp_t m;
        int   v, sel, n, seen0;

        start = 1'b0;
        value_in = 16'd0;
        usr_reset_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_is_fib", int'(is_fib), 0);
        chk("rst_fib_index", int'(fib_index), 0);
`ifdef FIB_FLOOR_EN
        chk("rst_floor_val", int'(floor_val), 0);
`endif

        // Pin the model to hand-derived values.
        m = model(55);    chk("model55_idx", m.idx, 10);    chk("model55_lat", m.lat, 10);
        m = model(1);     chk("model1_idx", m.idx, 1);
        m = model(65535); chk("model65535_lat", m.lat, 24); chk("model65535_floor", m.floor_v, 46368);
        m = model(100);   chk("model100_floor", m.floor_v, 89);

        #11 usr_reset_n = 1'b1;
        @(negedge clk); #1;

        issue(55); wait_done();
        chk("d55_is_fib", last_is_fib, 1); chk("d55_idx", last_idx, 10); chk("d55_busy", last_lat, 10);
        @(negedge clk); #1;
        issue(0); wait_done();
        chk("d0_is_fib", last_is_fib, 1); chk("d0_idx", last_idx, 0); chk("d0_busy", last_lat, 0);
        @(negedge clk); #1;
        issue(1); wait_done();
        chk("d1_idx", last_idx, 1);
        @(negedge clk); #1;
        issue(100); wait_done();
        chk("d100_is_fib", last_is_fib, 0);
`ifdef FIB_FLOOR_EN
        chk("d100_idx", last_idx, 11); chk("d100_floor", last_floor, 89);
`else
        chk("d100_idx", last_idx, 0);
`endif
        @(negedge clk); #1;
        issue(65535); wait_done();
        chk("d65535_is_fib", last_is_fib, 0); chk("d65535_busy", last_lat, 24);
`ifdef FIB_FLOOR_EN
        chk("d65535_idx", last_idx, 24); chk("d65535_floor", last_floor, 46368);
`endif
        // Back-to-back: new start while the previous result is in its done cycle.
        issue(8); wait_done();
        chk("b2b_is_fib", last_is_fib, 1); chk("b2b_idx", last_idx, 6);

        @(negedge clk); #1;
        issue(46368);
        repeat (3) @(negedge clk);
        start = 1'b1; value_in = 16'd5000;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        chk("ign_is_fib", last_is_fib, 1); chk("ign_idx", last_idx, 24);

        @(negedge clk); #1;
        issue(46368);
        repeat (5) @(negedge clk);
        #2 usr_reset_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_is_fib", int'(is_fib), 0);
        chk("abort_fib_index", int'(fib_index), 0);
`ifdef FIB_FLOOR_EN
        chk("abort_floor_val", int'(floor_val), 0);
`endif
        q.delete();
        repeat (2) @(negedge clk);
        #2 usr_reset_n = 1'b1;
        seen0 = done_seen;
        repeat (30) @(negedge clk);
        chk("no_done_after_abort", done_seen - seen0, 0);
        #1;

        for (int k = 0; k < 60; k++) begin
            sel = $urandom_range(0, 3);
            n   = $urandom_range(0, 24);
            case (sel)
                0:       v = $urandom_range(0, 65535);
                1:       v = fibn(n);
                2:       v = fibn(n) + 1;
                default: v = (fibn(n) > 0) ? fibn(n) - 1 : 0;
            endcase
            issue(v);
            wait_done();
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                #1;
            end
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
